// File: rtl/hazard_pkg.sv
// Shared decode constants, pipeline timing encodings and helper functions for the
// MIPS hazard/stall controller.
package hazard_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1A;
  localparam logic [5:0] FN_DIVU    = 6'h1B;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_SLT     = 6'h2A;

  localparam logic [1:0] T_0    = 2'd0;
  localparam logic [1:0] T_1    = 2'd1;
  localparam logic [1:0] T_2    = 2'd2;
  localparam logic [1:0] T_NONE = 2'd3;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef enum logic [3:0] {
    IC_NOP,
    IC_CALC_R,
    IC_CALC_I,
    IC_LOAD,
    IC_STORE,
    IC_BRANCH,
    IC_JR,
    IC_JAL,
    IC_MD_START,
    IC_MF,
    IC_MT
  } instr_class_t;

  typedef enum logic {
    MDU_IDLE,
    MDU_BUSY
  } mdu_state_t;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    logic [1:0] tnew_e;
    logic [4:0] dst;
    logic       md_start;
    logic       md_div;
    logic       md_use;
  } instr_info_t;

  // A source conflicts when it is read before the producer's result is available.
  function automatic logic src_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                      input logic [4:0] dst, input logic [1:0] tnew);
    return (src != REG_ZERO) && (src == dst) && (tuse != T_NONE) && (tuse < tnew);
  endfunction

  // Only a load still has a cycle to go once it reaches M.
  function automatic logic [1:0] tnew_in_m(input logic [1:0] tnew_e);
    return (tnew_e == T_2) ? T_1 : T_0;
  endfunction

endpackage

// File: rtl/instr_class_dec.sv
// Combinational instruction classifier: IR -> register usage timing, destination and
// mult/div unit involvement.
module instr_class_dec
  import hazard_pkg::*;
(
  input  logic [31:0]  i_ir,
  output instr_info_t  o_info
);

  logic [5:0]   w_op;
  logic [5:0]   w_fn;
  logic [4:0]   w_rs;
  logic [4:0]   w_rt;
  logic [4:0]   w_rd;
  instr_class_t w_cls;
  logic         w_unused;

  assign w_op     = i_ir[31:26];
  assign w_rs     = i_ir[25:21];
  assign w_rt     = i_ir[20:16];
  assign w_rd     = i_ir[15:11];
  assign w_fn     = i_ir[5:0];
  assign w_unused = ^i_ir[10:6];

  always_comb begin
    w_cls = IC_NOP;
    case (w_op)
      OP_SPECIAL: begin
        case (w_fn)
          FN_ADDU, FN_SUBU, FN_SLT:             w_cls = IC_CALC_R;
          FN_JR:                                w_cls = IC_JR;
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU:   w_cls = IC_MD_START;
          FN_MFHI, FN_MFLO:                     w_cls = IC_MF;
          FN_MTHI, FN_MTLO:                     w_cls = IC_MT;
          default:                              w_cls = IC_NOP;
        endcase
      end
      OP_ORI, OP_LUI, OP_ADDIU: w_cls = IC_CALC_I;
      OP_LW:                    w_cls = IC_LOAD;
      OP_SW:                    w_cls = IC_STORE;
      OP_BEQ, OP_BNE:           w_cls = IC_BRANCH;
      OP_JAL:                   w_cls = IC_JAL;
      default:                  w_cls = IC_NOP;
    endcase
  end

  always_comb begin
    o_info          = '0;
    o_info.rs       = w_rs;
    o_info.rt       = w_rt;
    o_info.tuse_rs  = T_NONE;
    o_info.tuse_rt  = T_NONE;
    o_info.tnew_e   = T_0;
    o_info.dst      = REG_ZERO;
    case (w_cls)
      IC_CALC_R: begin
        o_info.tuse_rs = T_1;
        o_info.tuse_rt = T_1;
        o_info.tnew_e  = T_1;
        o_info.dst     = w_rd;
      end
      IC_CALC_I: begin
        o_info.tuse_rs = T_1;
        o_info.tnew_e  = T_1;
        o_info.dst     = w_rt;
      end
      IC_LOAD: begin
        o_info.tuse_rs = T_1;
        o_info.tnew_e  = T_2;
        o_info.dst     = w_rt;
      end
      IC_STORE: begin
        o_info.tuse_rs = T_1;
        o_info.tuse_rt = T_2;
      end
      IC_BRANCH: begin
        o_info.tuse_rs = T_0;
        o_info.tuse_rt = T_0;
      end
      IC_JR:  o_info.tuse_rs = T_0;
      IC_JAL: o_info.dst     = REG_RA;
      IC_MD_START: begin
        // Operands are consumed in E like any other ALU operation.
        o_info.tuse_rs  = T_1;
        o_info.tuse_rt  = T_1;
        o_info.md_start = 1'b1;
        o_info.md_div   = (w_fn == FN_DIV) || (w_fn == FN_DIVU);
      end
      IC_MF: begin
        o_info.tnew_e = T_1;
        o_info.dst    = w_rd;
        o_info.md_use = 1'b1;
      end
      IC_MT: begin
        o_info.tuse_rs = T_1;
        o_info.md_use  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard detector: stalls F/D and bubbles D/E on read-after-write and
// mult/div unit conflicts, sequences the MDU busy window and counts stall cycles.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      D_IR,
  input  logic [31:0]      E_IR,
  input  logic [31:0]      M_IR,
  output logic             pc_en,
  output logic             fd_en,
  output logic             de_clear,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  logic [31:0]      w_ir   [3];
  instr_info_t      w_info [3];
  logic [1:0]       w_tnew_m;
  logic             w_stall_rw;
  logic             w_stall_md;
  logic             w_stall;
  mdu_state_t       w_mdu_state;
  logic [3:0]       r_mdu_cnt;
  logic [3:0]       w_mdu_cnt_next;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_unused;

  assign w_ir[0] = D_IR;
  assign w_ir[1] = E_IR;
  assign w_ir[2] = M_IR;

  // Index 0 = D, 1 = E, 2 = M.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dec
      instr_class_dec u_dec (
        .i_ir   (w_ir[gi]),
        .o_info (w_info[gi])
      );
    end
  endgenerate

  assign w_tnew_m = tnew_in_m(w_info[2].tnew_e);

  assign w_stall_rw =
      src_hazard(w_info[0].rs, w_info[0].tuse_rs, w_info[1].dst, w_info[1].tnew_e) |
      src_hazard(w_info[0].rt, w_info[0].tuse_rt, w_info[1].dst, w_info[1].tnew_e) |
      src_hazard(w_info[0].rs, w_info[0].tuse_rs, w_info[2].dst, w_tnew_m)         |
      src_hazard(w_info[0].rt, w_info[0].tuse_rt, w_info[2].dst, w_tnew_m);

  assign w_stall_md = (w_info[0].md_start | w_info[0].md_use) &
                      (mdu_busy | w_info[1].md_start);

  // Held inactive while reset is asserted so the pipeline runs freely out of reset.
  assign w_stall  = reset & (w_stall_rw | w_stall_md);
  assign pc_en    = ~w_stall;
  assign fd_en    = ~w_stall;
  assign de_clear = w_stall;

  assign w_mdu_state = (r_mdu_cnt == 4'd0) ? MDU_IDLE : MDU_BUSY;
  assign mdu_busy    = (w_mdu_state == MDU_BUSY);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mdu_cnt <= 4'd0;
    end else begin
      r_mdu_cnt <= w_mdu_cnt_next;
    end
  end

  // A start leaving E always (re)loads the counter, so the newest start wins.
  always_comb begin
    w_mdu_cnt_next = r_mdu_cnt;
    case (w_mdu_state)
      MDU_IDLE: begin
        if (w_info[1].md_start) begin
          w_mdu_cnt_next = w_info[1].md_div ? DIV_LOAD : MULT_LOAD;
        end
      end
      MDU_BUSY: begin
        if (w_info[1].md_start) begin
          w_mdu_cnt_next = w_info[1].md_div ? DIV_LOAD : MULT_LOAD;
        end else begin
          w_mdu_cnt_next = r_mdu_cnt - 4'd1;
        end
      end
      default: w_mdu_cnt_next = 4'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;

  assign w_unused = ^{w_info[0].tnew_e, w_info[0].dst, w_info[0].md_div,
                      w_info[1].rs, w_info[1].rt, w_info[1].tuse_rs, w_info[1].tuse_rt,
                      w_info[1].md_use,
                      w_info[2].rs, w_info[2].rt, w_info[2].tuse_rs, w_info[2].tuse_rt,
                      w_info[2].md_start, w_info[2].md_div, w_info[2].md_use};

endmodule
